reg_bank_write_arbiter: RTL and testbench
=========================================

// Module: reg_bank_write_arbiter
// PURPOSE
//   Owns a bank of DEPTH 8-bit storage registers and shares their write side among NREQ requesters.
//   Example requesters: the user-edit path and the RTC-readback path.
//   Round-robin arbitration; four-phase req/ack handshake per requester.
//   One write is sequenced at a time.
//   Registered read port feeds display/format logic.
// PARAMETERS
//   NREQ   2   number of write requesters (>=2)
//   DEPTH  8   number of 8-bit registers in the bank
//   AW     3   address width; 2**AW >= DEPTH
// PORTS
//   clk       in   1         system clock, rising edge
//   reset     in   1         asynchronous, active-high reset
//   req       in   NREQ      write request, one bit per requester; held until its ack
//   req_addr  in   NREQ*AW   requester i's address in bits [i*AW +: AW]
//   req_data  in   NREQ*8    requester i's data in bits [i*8 +: 8]
//   ack       out  NREQ      write done; one-hot; high until the granted req drops
//   wr_err    out  1         1-cycle pulse: granted address >= DEPTH, write dropped
//   busy      out  1         high in any state other than IDLE
//   rd_addr   in   AW        read address
//   rd_data   out  8         registered read data
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; bank[*]=8'h00; ack=0; wr_err=0; busy=0; rd_data=8'h00; rr_ptr=0.
//   FSM
//     IDLE -> LATCH when |req.
//       Winner = first asserted req scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//       Latch winner idx, addr and data into holding regs.
//     LATCH -> COMMIT unconditionally, one cycle.
//     COMMIT:
//       addr < DEPTH: bank[addr] <= data.
//       addr >= DEPTH: no write; wr_err=1 for this edge only.
//       Set ack[idx]=1; -> WAIT.
//     WAIT: hold ack[idx]=1 until req[idx]=0 is sampled.
//       Then ack=0, rr_ptr <= (idx+1) mod NREQ, -> IDLE.
//   Timing
//     req sampled at edge E: latched at E, bank written and ack high at E+2.
//     Next grant is no earlier than the edge after ack falls.
//   Latched addr/data are frozen.
//     Requester changes after edge E are ignored for that transaction.
//   Non-granted requesters keep waiting; req may be held indefinitely; no request is lost.
//   ack is only ever asserted to the latched idx; at most one ack bit is high.
//   Read port: rd_data <= bank[rd_addr] every edge; 1-cycle latency.
//     rd_addr >= DEPTH reads 8'h00.
//     Same-edge write and read of one address returns the pre-write value; new value next cycle.
//   Fairness: with all NREQ requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0,...
//   Reset mid-transaction aborts it: the bank write is lost if not yet in COMMIT; ack drops at once.
//   req dropped before ack (protocol violation):
//     The transaction still completes.
//     ack pulses one cycle in WAIT, since req[idx]=0 is sampled immediately.
// TESTING
//   1. Reset mid-WAIT with ack[0]=1 -> ack=0 and busy=0 at once; bank reads 8'h00; next grant goes to requester 0.
//   2. Single write: req[0], addr 3, data 8'hA5 at E.
//      -> ack[0]=1 at E+2.
//      -> rd_addr=3 gives rd_data=8'hA5 one cycle later.
//      -> Drop req[0]: ack=0, busy=0 next edge.
//   3. Contention: req=2'b11 from reset, data 8'h11 and 8'h22 to addr 0.
//      -> requester 0 granted first, then requester 1.
//      -> bank[0]=8'h22 at the end; the grant order alternates on repeat.
//   4. Out-of-range: req[1], addr 7 with DEPTH=6 -> wr_err pulses once with ack[1]; bank unchanged; rd_data at addr 7 = 8'h00.
//   5. Frozen data: req[0], addr 2, data 8'h5A; change data to 8'hFF one cycle later -> bank[2]=8'h5A.
//   6. Starvation: req[1] held while req[0] toggles back-to-back -> requester 1 granted no later than the second arbitration.

Source files
------------

// File: rtl/reg_bank_write_arbiter.sv
// Bank of DEPTH 8-bit registers whose write side is shared round-robin among NREQ
// requesters over a four-phase req/ack handshake, with a registered read port.
module reg_bank_write_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*8-1:0]    req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 wr_err,
  output logic                 busy,
  input  logic [AW-1:0]        rd_addr,
  output logic [7:0]           rd_data
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate among asserted requests
  // LATCH  | winner's index/addr/data captured, one settling cycle
  // COMMIT | write the bank (or flag wr_err), raise ack
  // WAIT   | hold ack until the granted req drops
  typedef enum logic [1:0] {IDLE, LATCH, COMMIT, WAIT} state_t;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            wr_err_q, wr_err_d;
  logic            bank_we;
  logic [7:0]      bank_q [DEPTH];
  logic [7:0]      rd_data_q, rd_data_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [AW-1:0]   win_addr;
  logic [7:0]      win_data;
  int              scan_j;
  logic            addr_ok;

  assign addr_ok = ({1'b0, addr_q} < DEPTH_W);

  // First asserted request starting from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    win_data  = '0;
    scan_j    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_j = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_found && req[scan_j]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_j);
        win_addr  = req_addr[scan_j*AW +: AW];
        win_data  = req_data[scan_j*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ack_d    = ack_q;
    wr_err_d = 1'b0;
    rr_ptr_d = rr_ptr_q;
    bank_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LATCH;
          idx_d   = win_idx;
          addr_d  = win_addr;
          data_d  = win_data;
        end
      end
      LATCH: state_d = COMMIT;
      COMMIT: begin
        bank_we       = addr_ok;
        wr_err_d      = !addr_ok;
        ack_d         = '0;
        ack_d[idx_q]  = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        if (!req[idx_q]) begin
          ack_d    = '0;
          rr_ptr_d = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) rd_data_d = bank_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      wr_err_q  <= 1'b0;
      rd_data_q <= 8'h00;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      wr_err_q  <= wr_err_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (bank_we && addr_q == AW'(i)) bank_q[i] <= data_q;
      end
    end
  end

  assign ack     = ack_q;
  assign wr_err  = wr_err_q;
  assign busy    = (state_q != IDLE);
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed bench for reg_bank_write_arbiter (NREQ=2, DEPTH=6, AW=3); expected grants
// are queued as requests are driven and checked when ack rises.
module tb_reg_bank_write_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 6;
  localparam int AW    = 3;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*8-1:0]   req_data;
  logic [NREQ-1:0]     ack;
  logic                wr_err;
  logic                busy;
  logic [AW-1:0]       rd_addr;
  logic [7:0]          rd_data;

  typedef struct {
    int         idx;
    int         addr;
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] model [8];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         last_lat = 0;

  reg_bank_write_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .wr_err   (wr_err),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int i, input int addr, input logic [7:0] data);
    exp_t e;
    req_addr[i*AW +: AW] = AW'(addr);
    req_data[i*8 +: 8]   = data;
    req[i]               = 1'b1;
    e.idx  = i;
    e.addr = addr;
    e.data = data;
    e.err  = (addr >= DEPTH);
    sbq.push_back(e);
  endtask

  task automatic wait_ack(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (ack == '0 && n < 20) begin
      tick();
      n++;
    end
    last_lat = n;
    chk({tag, "_seen"}, 32'(ack != '0), 1);
    chk({tag, "_sbq"}, 32'(sbq.size() > 0), 1);
    if (ack != '0 && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_ack"}, 32'(ack), 32'(1) << e.idx);
      chk({tag, "_wr_err"}, 32'(wr_err), 32'(e.err));
      if (!e.err) model[e.addr] = e.data;
    end
  endtask

  task automatic rd_check(input int addr, input string tag);
    rd_addr = AW'(addr);
    tick();
    chk($sformatf("%s_rd%0d", tag, addr), 32'(rd_data), (addr < DEPTH) ? 32'(model[addr]) : 32'h0);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 8; a++) rd_check(a, tag);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    rd_addr  = '0;
    for (int a = 0; a < 8; a++) model[a] = 8'h00;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    tick();

    // Single write with exact latency and same-edge read-before-write.
    rd_addr = 3'd3;
    drive_req(0, 3, 8'hA5);
    wait_ack("single");
    chk("single_latency", 32'(last_lat), 3);
    chk("single_busy", 32'(busy), 1);
    chk("single_rd_old", 32'(rd_data), 32'h00);
    tick();
    chk("single_rd_new", 32'(rd_data), 32'hA5);
    req[0] = 1'b0;
    tick();
    chk("single_rel_ack", 32'(ack), 0);
    chk("single_rel_busy", 32'(busy), 0);

    // Frozen data: change after the latching edge must not reach the bank.
    drive_req(0, 2, 8'h5A);
    tick();
    req_data[7:0] = 8'hFF;
    wait_ack("frozen");
    req[0] = 1'b0;
    tick();
    rd_check(2, "frozen");

    // Out-of-range address: error pulse, no write.
    drive_req(1, 7, 8'h77);
    wait_ack("oor");
    tick();
    chk("oor_err_pulse", 32'(wr_err), 0);
    chk("oor_ack_hold", 32'(ack), 32'b10);
    req[1] = 1'b0;
    tick();
    chk("oor_rel_ack", 32'(ack), 0);
    rd_check(7, "oor");
    rd_check(3, "oor");

    // req dropped before ack: transaction completes, ack pulses one cycle.
    drive_req(0, 5, 8'h55);
    tick();
    req[0] = 1'b0;
    wait_ack("early_drop");
    tick();
    chk("early_drop_ack_pulse", 32'(ack), 0);
    rd_check(5, "early_drop");

    // Reset while in WAIT: ack and busy drop immediately, bank cleared, pointer back to 0.
    drive_req(0, 4, 8'h44);
    wait_ack("rst_mid");
    reset = 1'b1;
    req   = '0;
    #1;
    chk("rst_mid_ack", 32'(ack), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    for (int a = 0; a < 8; a++) model[a] = 8'h00;
    tick();
    reset = 1'b0;
    read_all("after_rst");

    // Contention and fairness: requester 1 held while requester 0 re-requests back-to-back.
    drive_req(0, 0, 8'h11);
    drive_req(1, 0, 8'h22);
    wait_ack("cont0");
    req[0] = 1'b0;
    tick();
    chk("cont0_rel", 32'(ack), 0);
    drive_req(0, 0, 8'h33);
    wait_ack("cont1");
    req[1] = 1'b0;
    tick();
    chk("cont1_rel", 32'(ack), 0);
    drive_req(1, 0, 8'h44);
    rd_check(0, "cont1");
    wait_ack("cont2");
    req[0] = 1'b0;
    tick();
    wait_ack("starve");
    req[1] = 1'b0;
    tick();
    chk("cont_end_ack", 32'(ack), 0);
    chk("cont_end_busy", 32'(busy), 0);
    chk("sbq_drained", 32'(sbq.size()), 0);
    read_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
